pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised inter-stage pipeline register, the generalised successor of the fixed decode→execute latch. It carries NCH parallel issue lanes of WIDTH-bit packed control/operand payload, honours the global 6-bit stall vector with bubble insertion, and adds a flush input, per-lane kill, per-lane valid bits, a saturating bubble counter and a stall-hold watchdog. One instance sits between each pair of stages (IF/ID, ID/EX, EX/MEM, MEM/WB), with STAGE selecting which stall bits it obeys.

## Interface
- WIDTH, 64: payload bits per lane (aluop, alusel, operands, dest, link address, inst are packed by the instantiating stage)
- NCH, 2: number of issue lanes
- STALL_W, 6: width of the global stall vector
- STAGE, 2: index of the upstream stage in the stall vector; requires STAGE+1 < STALL_W
- NOP_DATA, 0: WIDTH-bit payload value of an empty/bubble lane
- CNT_W, 16: bubble counter width
- TIMEOUT, 255: consecutive hold cycles before hold_timeout asserts; 1 ≤ TIMEOUT ≤ 2^CNT_W−1
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-low reset
- stall  in  STALL_W  global stall vector from the stall controller
- flush  in  1  squash contents (branch redirect / exception)
- in_valid  in  NCH  lane valid from upstream stage
- in_kill  in  NCH  lane squash applied at capture
- in_data  in  NCH*WIDTH  lane payloads, lane i at [i*WIDTH +: WIDTH]
- out_valid  out  NCH  registered lane valid
- out_data  out  NCH*WIDTH  registered lane payloads
- bubble_cnt  out  CNT_W  number of bubbles inserted, saturating
- hold_timeout  out  1  held longer than TIMEOUT cycles

## Operation
- Per rising edge, exactly one action, priority order:
  1. RESET (rst==0): out_valid=0, all lanes out_data=NOP_DATA, bubble_cnt=0, hold counter=0, hold_timeout=0.
  2. FLUSH (flush==1): out_valid=0, all lanes NOP_DATA. Counters: bubble_cnt unchanged, hold counter cleared.
  3. BUBBLE (stall[STAGE]==1 && stall[STAGE+1]==0): out_valid=0, all lanes NOP_DATA; bubble_cnt+1 (saturates at all-ones); hold counter cleared.
  4. CAPTURE (stall[STAGE]==0): per lane v=in_valid[i]&~in_kill[i]; out_valid[i]=v; out_data lane i = v ? in_data lane : NOP_DATA. Hold counter cleared.
  5. HOLD (stall[STAGE]==1 && stall[STAGE+1]==1): outputs unchanged. If any out_valid bit set, hold counter +1, saturating at TIMEOUT; otherwise hold counter cleared.
- hold_timeout is registered: 1 while hold counter == TIMEOUT, else 0.
- Stall bits other than STAGE and STAGE+1 are ignored.
- Invalid lane always presents NOP_DATA; downstream may ignore out_valid and still see a NOP.
- Lanes are independent in data, shared in control: the action is decided once for all lanes.

## Timing
- Latency 1 cycle: inputs sampled on edge N appear on outputs after edge N.
- All outputs registered; no combinational input→output path.
- Flush simultaneous with bubble or capture: flush wins, bubble not counted.
- Reset simultaneous with anything: reset wins.
- in_kill only acts in CAPTURE; ignored during HOLD (held lanes are not killable; use flush).
- bubble_cnt at all-ones stays there on further bubbles.
- hold_timeout rises on the edge where the hold counter reaches TIMEOUT, falls on the first non-HOLD edge or first HOLD edge with out_valid==0.
- Reset mid-hold clears hold_timeout on that edge.

## Structure
- Shared package/defines: stall vector width, NOP payload constant, lane payload field offsets, reset-enable polarity constant.
- One natural sub-module: pipe_lane_reg (single-lane valid+payload register with capture/clear/hold controls), instantiated NCH times via generate; action decode and counters live in the top.

## Test plan
- Reset: rst=0 one cycle with in_valid=2'b11, stall=0 → out_valid=0, out_data all NOP_DATA, bubble_cnt=0, hold_timeout=0.
- Capture with kill: stall=0, in_valid=2'b11, in_kill=2'b10, lane0=0x1111, lane1=0x2222 → next cycle out_valid=2'b01, lane0=0x1111, lane1=NOP_DATA.
- Bubble: stall=6'b000111 (STAGE=2) for 3 cycles → out_valid=0 each cycle, bubble_cnt=3; then stall=6'b001111 → outputs held, count stays 3.
- Flush priority: flush=1 with stall=6'b000111 → outputs cleared, bubble_cnt unchanged.
- Watchdog: TIMEOUT=4, out_valid=2'b01, stall=6'b001111 held 6 cycles → hold_timeout rises after 4th hold edge, stays 1; stall=0 → falls next edge.
- Saturation: CNT_W=4, 17 consecutive bubble cycles → bubble_cnt=15.

Source files
------------

// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the inter-stage pipeline register: stall vector
// geometry, the empty-lane payload, packed payload field offsets, reset
// polarity and the per-edge action decode.
package pipe_stage_reg_pkg;

    localparam int          STALL_W_DEF   = 6;
    localparam int          PAYLOAD_W_DEF = 64;
    localparam logic [63:0] NOP_PAYLOAD   = 64'h0000_0000_0000_0000;

    // Payload field offsets as packed by the instantiating stage.
    localparam int FLD_ALUOP_LSB  = 0;
    localparam int FLD_ALUSEL_LSB = 8;
    localparam int FLD_DEST_LSB   = 11;
    localparam int FLD_LINK_LSB   = 16;
    localparam int FLD_INST_LSB   = 32;

    // Level of rst that resets the block.
    localparam logic RST_ACTIVE = 1'b0;

    typedef enum logic [2:0] {
        ACT_RESET   = 3'd0,
        ACT_FLUSH   = 3'd1,
        ACT_BUBBLE  = 3'd2,
        ACT_CAPTURE = 3'd3,
        ACT_HOLD    = 3'd4
    } action_e;

    // Reset is handled by the registers themselves; this picks among the
    // remaining actions in priority order.
    function automatic action_e decode_action(input logic flush_v,
                                              input logic stall_up_v,
                                              input logic stall_dn_v);
        action_e act;
        if (flush_v) begin
            act = ACT_FLUSH;
        end else if (!stall_up_v) begin
            act = ACT_CAPTURE;
        end else if (!stall_dn_v) begin
            act = ACT_BUBBLE;
        end else begin
            act = ACT_HOLD;
        end
        return act;
    endfunction

endpackage

// File: rtl/pipe_lane_reg.sv
// Single issue lane: valid bit plus payload, with capture / clear / hold.
// An invalid lane always carries NOP_DATA.
module pipe_lane_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int               WIDTH    = 64,
    parameter logic [WIDTH-1:0] NOP_DATA = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cap_i,
    input  logic             clr_i,
    input  logic             in_valid_i,
    input  logic             in_kill_i,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    output logic [WIDTH-1:0] out_data_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q,  data_d;

    // Next lane contents: clear wins over capture; otherwise hold.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (clr_i) begin
            valid_d = 1'b0;
            data_d  = NOP_DATA;
        end else if (cap_i) begin
            valid_d = in_valid_i & ~in_kill_i;
            data_d  = (in_valid_i & ~in_kill_i) ? in_data_i : NOP_DATA;
        end else begin
            valid_d = valid_q;
            data_d  = data_q;
        end
    end

    // Lane state register with synchronous reset to an empty lane.
    always_ff @(posedge clk) begin
        if (rst == RST_ACTIVE) begin
            valid_q <= 1'b0;
            data_q  <= NOP_DATA;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register: NCH lanes, stall/bubble
// handling from the global stall vector, flush, per-lane kill, a saturating
// bubble counter and a stall-hold watchdog.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int               WIDTH    = PAYLOAD_W_DEF,
    parameter int               NCH      = 2,
    parameter int               STALL_W  = STALL_W_DEF,
    parameter int               STAGE    = 2,
    parameter logic [WIDTH-1:0] NOP_DATA = NOP_PAYLOAD[WIDTH-1:0],
    parameter int               CNT_W    = 16,
    parameter int               TIMEOUT  = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [STALL_W-1:0]   stall,
    input  logic                 flush,
    input  logic [NCH-1:0]       in_valid,
    input  logic [NCH-1:0]       in_kill,
    input  logic [NCH*WIDTH-1:0] in_data,
    output logic [NCH-1:0]       out_valid,
    output logic [NCH*WIDTH-1:0] out_data,
    output logic [CNT_W-1:0]     bubble_cnt,
    output logic                 hold_timeout
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    action_e          action_s;
    logic             cap_s;
    logic             clr_s;
    logic [CNT_W-1:0] bubble_q, bubble_d;
    logic [CNT_W-1:0] hold_q,   hold_d;
    logic             timeout_q, timeout_d;
    logic             stall_unused_s;

    // Only stall[STAGE] and stall[STAGE+1] matter to this instance.
    assign stall_unused_s = ^stall;

    // Decide the single action shared by all lanes this edge.
    always_comb begin
        action_s = decode_action(flush, stall[STAGE], stall[STAGE+1]);
        cap_s    = 1'b0;
        clr_s    = 1'b0;
        case (action_s)
            ACT_CAPTURE: begin
                cap_s = 1'b1;
                clr_s = 1'b0;
            end
            ACT_FLUSH, ACT_BUBBLE: begin
                cap_s = 1'b0;
                clr_s = 1'b1;
            end
            default: begin
                cap_s = 1'b0;
                clr_s = 1'b0;
            end
        endcase
    end

    // Counter next-state: bubbles count up and stick at all-ones; the hold
    // counter only runs while valid contents are held, capped at TIMEOUT.
    always_comb begin
        bubble_d = bubble_q;
        hold_d   = '0;
        case (action_s)
            ACT_BUBBLE: begin
                if (bubble_q != CNT_MAX) begin
                    bubble_d = bubble_q + CNT_ONE;
                end else begin
                    bubble_d = bubble_q;
                end
            end
            ACT_HOLD: begin
                if (|out_valid) begin
                    hold_d = (hold_q == TIMEOUT_C) ? hold_q : (hold_q + CNT_ONE);
                end else begin
                    hold_d = '0;
                end
            end
            default: begin
                hold_d = '0;
            end
        endcase
        timeout_d = (hold_d == TIMEOUT_C);
    end

    // Counter and watchdog registers.
    always_ff @(posedge clk) begin
        if (rst == RST_ACTIVE) begin
            bubble_q  <= '0;
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            bubble_q  <= bubble_d;
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_lane
            pipe_lane_reg #(
                .WIDTH    (WIDTH),
                .NOP_DATA (NOP_DATA)
            ) u_lane (
                .clk         (clk),
                .rst         (rst),
                .cap_i       (cap_s),
                .clr_i       (clr_s),
                .in_valid_i  (in_valid[gi]),
                .in_kill_i   (in_kill[gi]),
                .in_data_i   (in_data[gi*WIDTH +: WIDTH]),
                .out_valid_o (out_valid[gi]),
                .out_data_o  (out_data[gi*WIDTH +: WIDTH])
            );
        end
    endgenerate

    assign bubble_cnt   = bubble_q;
    assign hold_timeout = timeout_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed vector table, hand
// sequences for watchdog / saturation / reset-mid-hold, then random stimulus
// against a behavioural model.
module tb_pipe_stage_reg;

    localparam int          W     = 16;
    localparam int          N     = 2;
    localparam int          SW    = 6;
    localparam int          STG   = 2;
    localparam logic [15:0] NOP   = 16'hDEAD;
    localparam int          CW    = 4;
    localparam int          TMO   = 4;
    localparam int          CMAX  = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic [SW-1:0] stall;
    logic          flush;
    logic [N-1:0]  in_valid, in_kill;
    logic [N*W-1:0] in_data;
    logic [N-1:0]  out_valid;
    logic [N*W-1:0] out_data;
    logic [CW-1:0] bubble_cnt;
    logic          hold_timeout;

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    logic [1:0]  m_valid;
    logic [15:0] m_data [2];
    int          m_bub;
    int          m_hold;
    logic        m_to;

    pipe_stage_reg #(
        .WIDTH(W), .NCH(N), .STALL_W(SW), .STAGE(STG),
        .NOP_DATA(NOP), .CNT_W(CW), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_kill(in_kill), .in_data(in_data),
        .out_valid(out_valid), .out_data(out_data),
        .bubble_cnt(bubble_cnt), .hold_timeout(hold_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic [5:0]  st;
        logic        fl;
        logic [1:0]  iv;
        logic [1:0]  ik;
        logic [15:0] d0;
        logic [15:0] d1;
        logic [1:0]  ev;
        logic [15:0] e0;
        logic [15:0] e1;
        logic [3:0]  eb;
        logic        et;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Apply the rules for one edge to the model.
    task automatic model_step(input logic r, input logic [5:0] st, input logic fl,
                              input logic [1:0] iv, input logic [1:0] ik,
                              input logic [15:0] d0, input logic [15:0] d1);
        logic [15:0] din [2];
        din[0] = d0;
        din[1] = d1;
        if (!r) begin
            m_valid = 2'b00; m_data[0] = NOP; m_data[1] = NOP;
            m_bub = 0; m_hold = 0;
        end else if (fl) begin
            m_valid = 2'b00; m_data[0] = NOP; m_data[1] = NOP;
            m_hold = 0;
        end else if (!st[STG]) begin
            for (int i = 0; i < 2; i++) begin
                m_valid[i] = iv[i] && !ik[i];
                m_data[i]  = m_valid[i] ? din[i] : NOP;
            end
            m_hold = 0;
        end else if (!st[STG+1]) begin
            m_valid = 2'b00; m_data[0] = NOP; m_data[1] = NOP;
            m_bub = (m_bub < CMAX) ? m_bub + 1 : CMAX;
            m_hold = 0;
        end else begin
            if (m_valid != 2'b00) m_hold = (m_hold < TMO) ? m_hold + 1 : TMO;
            else m_hold = 0;
        end
        m_to = (m_hold == TMO);
    endtask

    // Drive one cycle, advance the model, compare all outputs to the model.
    task automatic cyc(input logic r, input logic [5:0] st, input logic fl,
                       input logic [1:0] iv, input logic [1:0] ik,
                       input logic [15:0] d0, input logic [15:0] d1);
        rst = r; stall = st; flush = fl; in_valid = iv; in_kill = ik;
        in_data = {d1, d0};
        model_step(r, st, fl, iv, ik, d0, d1);
        @(posedge clk);
        #1;
        chk("m_valid", 32'(out_valid), 32'(m_valid));
        chk("m_data0", 32'(out_data[15:0]), 32'(m_data[0]));
        chk("m_data1", 32'(out_data[31:16]), 32'(m_data[1]));
        chk("m_bubble", 32'(bubble_cnt), 32'(m_bub));
        chk("m_timeout", 32'(hold_timeout), 32'(m_to));
    endtask

    localparam logic [5:0] S_RUN  = 6'b000000;
    localparam logic [5:0] S_BUB  = 6'b000111;
    localparam logic [5:0] S_HOLD = 6'b001111;

    initial begin
        m_valid = 2'b00; m_data[0] = NOP; m_data[1] = NOP;
        m_bub = 0; m_hold = 0; m_to = 1'b0;

        //            r   stall        fl  iv     ik     d0        d1        ev     e0        e1        eb    et
        tbl[0]  = '{1'b0, S_RUN,       1'b0, 2'b11, 2'b00, 16'h1111, 16'h2222, 2'b00, NOP,      NOP,      4'd0, 1'b0};
        tbl[1]  = '{1'b1, S_RUN,       1'b0, 2'b11, 2'b10, 16'h1111, 16'h2222, 2'b01, 16'h1111, NOP,      4'd0, 1'b0};
        tbl[2]  = '{1'b1, S_BUB,       1'b0, 2'b11, 2'b00, 16'h1234, 16'h5678, 2'b00, NOP,      NOP,      4'd1, 1'b0};
        tbl[3]  = '{1'b1, S_BUB,       1'b0, 2'b11, 2'b00, 16'h1234, 16'h5678, 2'b00, NOP,      NOP,      4'd2, 1'b0};
        tbl[4]  = '{1'b1, S_BUB,       1'b0, 2'b11, 2'b00, 16'h1234, 16'h5678, 2'b00, NOP,      NOP,      4'd3, 1'b0};
        tbl[5]  = '{1'b1, S_RUN,       1'b0, 2'b11, 2'b00, 16'h3333, 16'h4444, 2'b11, 16'h3333, 16'h4444, 4'd3, 1'b0};
        tbl[6]  = '{1'b1, S_HOLD,      1'b0, 2'b11, 2'b11, 16'h5555, 16'h6666, 2'b11, 16'h3333, 16'h4444, 4'd3, 1'b0};
        tbl[7]  = '{1'b1, S_BUB,       1'b1, 2'b11, 2'b00, 16'h5555, 16'h6666, 2'b00, NOP,      NOP,      4'd3, 1'b0};
        tbl[8]  = '{1'b1, S_HOLD,      1'b0, 2'b11, 2'b00, 16'h5555, 16'h6666, 2'b00, NOP,      NOP,      4'd3, 1'b0};
        tbl[9]  = '{1'b1, 6'b110000,   1'b0, 2'b10, 2'b00, 16'h7777, 16'h8888, 2'b10, NOP,      16'h8888, 4'd3, 1'b0};
        tbl[10] = '{1'b1, 6'b111011,   1'b0, 2'b01, 2'b01, 16'h9999, 16'hAAAA, 2'b00, NOP,      NOP,      4'd3, 1'b0};
        tbl[11] = '{1'b1, S_RUN,       1'b1, 2'b11, 2'b00, 16'hBBBB, 16'hCCCC, 2'b00, NOP,      NOP,      4'd3, 1'b0};
        tbl[12] = '{1'b0, S_BUB,       1'b0, 2'b11, 2'b00, 16'hBBBB, 16'hCCCC, 2'b00, NOP,      NOP,      4'd0, 1'b0};

        for (int i = 0; i < 13; i++) begin
            cyc(tbl[i].r, tbl[i].st, tbl[i].fl, tbl[i].iv, tbl[i].ik, tbl[i].d0, tbl[i].d1);
            chk($sformatf("t%0d_valid", i), 32'(out_valid), 32'(tbl[i].ev));
            chk($sformatf("t%0d_data0", i), 32'(out_data[15:0]), 32'(tbl[i].e0));
            chk($sformatf("t%0d_data1", i), 32'(out_data[31:16]), 32'(tbl[i].e1));
            chk($sformatf("t%0d_bubble", i), 32'(bubble_cnt), 32'(tbl[i].eb));
            chk($sformatf("t%0d_timeout", i), 32'(hold_timeout), 32'(tbl[i].et));
        end

        // Watchdog: one valid lane held for six edges.
        cyc(1'b1, S_RUN, 1'b0, 2'b01, 2'b00, 16'h0ABC, 16'h0DEF);
        for (int k = 1; k <= 6; k++) begin
            cyc(1'b1, S_HOLD, 1'b0, 2'b11, 2'b00, 16'hFFFF, 16'hFFFF);
            chk($sformatf("wd_hold%0d", k), 32'(hold_timeout), (k >= TMO) ? 32'd1 : 32'd0);
        end
        chk("wd_held_data", 32'(out_data[15:0]), 32'h0ABC);
        cyc(1'b1, S_RUN, 1'b0, 2'b00, 2'b00, 16'h0000, 16'h0000);
        chk("wd_fall", 32'(hold_timeout), 32'd0);

        // Reset in the middle of a timed-out hold.
        cyc(1'b1, S_RUN, 1'b0, 2'b10, 2'b00, 16'h0000, 16'h4321);
        for (int k = 0; k < 5; k++) cyc(1'b1, S_HOLD, 1'b0, 2'b00, 2'b00, 16'h0, 16'h0);
        chk("rh_before", 32'(hold_timeout), 32'd1);
        cyc(1'b0, S_HOLD, 1'b0, 2'b00, 2'b00, 16'h0, 16'h0);
        chk("rh_after", 32'(hold_timeout), 32'd0);

        // Saturation: 17 consecutive bubbles from zero.
        for (int k = 1; k <= 17; k++) cyc(1'b1, S_BUB, 1'b0, 2'b11, 2'b00, 16'h1, 16'h2);
        chk("sat_bubble", 32'(bubble_cnt), 32'd15);

        // Random stimulus against the model.
        for (int k = 0; k < 400; k++) begin
            logic        r, fl;
            logic [5:0]  st;
            r  = ($urandom_range(0, 39) != 0);
            fl = ($urandom_range(0, 9) == 0);
            st = 6'($urandom);
            if ($urandom_range(0, 2) == 0) st[STG+1 -: 2] = 2'b11;
            cyc(r, st, fl, 2'($urandom), 2'($urandom), 16'($urandom), 16'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
